bfa_serial_ctrl: RTL
====================

Name: bfa_serial_ctrl

Overview:
- Bit-serial add controller that time-multiplexes one external single-bit full adder (bfa_gate) to add two WIDTH-bit operands.
- Sequences the operand bits LSB-first through the adder, holds the running carry in a register and assembles the sum.
- Presents a start/busy/done handshake to the requesting logic.
- Sits between operand-producing logic and the shared bfa_gate instance; the bfa_gate stays purely combinational.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when accepting (see Behaviour).
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- cin  input  1  carry-in, latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result commits.
- sum  output  WIDTH  committed sum; holds until next commit.
- cout  output  1  committed carry-out; holds until next commit.
- bfa_i0  output  1  to bfa_gate i0.
- bfa_i1  output  1  to bfa_gate i1.
- bfa_ci  output  1  to bfa_gate ci.
- bfa_sout  input  1  from bfa_gate sout.
- bfa_cout  input  1  from bfa_gate cout.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and bit counter = 0; bfa_i0/i1/ci = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - bfa_i0=a_sh[0], bfa_i1=b_sh[0], bfa_ci=carry; all driven combinationally from registers.
  - Each edge: s_sh<={bfa_sout, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right with 0 fill; carry<=bfa_cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge, k+WIDTH): commit sum<={bfa_sout, s_sh[WIDTH-1:1]} and cout<=bfa_cout; state<=DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - Next edge: start=1 is accepted exactly as in IDLE (goes to RUN); otherwise state<=IDLE.
- Latency: start sampled at edge k gives done high during the cycle after edge k+WIDTH. Throughput is one add per WIDTH+1 cycles.
- start during RUN: ignored; no queueing, no effect on the operation in progress.
- Outside RUN: bfa_i0/i1/ci driven 0.
- sum/cout change only at commit; they are never partially updated during RUN.
- Reset mid-RUN: operation aborted, no done pulse, outputs return to reset values.
- cnt width: clog2(WIDTH+1); it never wraps past WIDTH-1.
- WIDTH=1: RUN lasts exactly one cycle.

Optional Feature:
- Macro: BFA_SERIAL_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), two's-complement overflow.
  - ovf = (carry into MSB) XOR (carry out of MSB). Computed at commit as bfa_ci XOR bfa_cout on the final RUN edge.
  - Registered with sum; reset 0; holds until next commit.
- Undefined: ovf port and its logic do not exist; all other behaviour identical.

Test Plan:
- Reset mid-op: start with a=0xFF, b=0x01, assert rst after 3 RUN cycles -> busy=0, done never pulses, sum=0x00, cout=0, bfa_* = 0.
- Basic carry chain (WIDTH=8): a=0xFF, b=0x01, cin=0 at edge 0 -> busy high 8 cycles, done pulse after edge 8, sum=0x00, cout=1.
- Carry-in: a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Start while busy: second start with a=0x01, b=0x01 at RUN cycle 4 of 0x0F+0x01 -> ignored, result sum=0x10, cout=0, exactly one done pulse.
- Back-to-back: start held high through the DONE cycle with a=0x80, b=0x80 -> re-enters RUN with no IDLE cycle; second done 9 cycles after first, sum=0x00, cout=1.
- BFA_SERIAL_OVF_EN defined: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/bfa_serial_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through one external
// combinational full adder (bfa_gate). Define BFA_SERIAL_OVF_EN to add a registered overflow output.
module bfa_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef BFA_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             bfa_i0,
    output logic             bfa_i1,
    output logic             bfa_ci,
    input  logic             bfa_sout,
    input  logic             bfa_cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] s_next;

    // A one-bit sum register has no upper bits to shift down, so the new bit is the whole word.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_next = bfa_sout;
        end else begin : g_wn
            assign s_next = {bfa_sout, s_sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_sh_d  = s_next;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = bfa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Carry into the MSB is the registered carry feeding the adder on this last bit.
                    sum_d   = s_next;
                    cout_d  = bfa_cout;
                    ovf_d   = carry_q ^ bfa_cout;
                    cnt_d   = cnt_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign sum    = sum_q;
    assign cout   = cout_q;
    assign bfa_i0 = busy & a_sh_q[0];
    assign bfa_i1 = busy & b_sh_q[0];
    assign bfa_ci = busy & carry_q;

`ifdef BFA_SERIAL_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
